// File: rtl/immediate_encoder_if.sv
// rtl/immediate_encoder_if.sv - request/response bundle for the immediate encoder
interface immediate_encoder_if;
    logic [2:0]  format_i;
    logic [31:0] immediate_i;
    logic [31:0] base_i;
    logic        valid_i;
    logic        ready_o;
    logic        clear_i;
    logic [31:0] instruction_o;
    logic [31:0] address_o;
    logic        error_o;
    logic        valid_o;
    logic        ready_i;
    logic [7:0]  err_count_o;

    modport master (
        output format_i, immediate_i, base_i, valid_i, clear_i, ready_i,
        input  ready_o, instruction_o, address_o, error_o, valid_o, err_count_o
    );

    modport slave (
        input  format_i, immediate_i, base_i, valid_i, clear_i, ready_i,
        output ready_o, instruction_o, address_o, error_o, valid_o, err_count_o
    );
endinterface

// File: rtl/immediate_encoder.sv
// rtl/immediate_encoder.sv - packs an immediate into an instruction word and emits it with an address
module immediate_encoder #(
    parameter logic [31:0] START_ADDR = 32'h0040_0000
) (
    input logic               clk,
    input logic               reset,
    immediate_encoder_if.slave bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, ENCODE, OUTPUT} state_t;

    state_t      state;
    logic [2:0]  fmt_q;
    logic [31:0] imm_q;
    logic [31:0] base_q;
    logic        ready_q;
    logic        valid_q;
    logic        err_q;
    logic [31:0] instr_q;
    logic [31:0] addr_q;
    logic [7:0]  cnt_q;
    logic [31:0] enc_word;
    logic        enc_err;

    assign bus.ready_o       = ready_q;
    assign bus.valid_o       = valid_q;
    assign bus.error_o       = err_q;
    assign bus.instruction_o = instr_q;
    assign bus.address_o     = addr_q;
    assign bus.err_count_o   = cnt_q;

    // Scatter the immediate; an immediate that would not decode back to itself yields a NOP.
    always_comb begin
        enc_word = base_q;
        enc_err  = 1'b0;
        case (fmt_q)
            3'd0: enc_err = 1'b0;
            3'd1: begin
                enc_word[31:20] = imm_q[11:0];
                enc_err = !((&imm_q[31:11]) || !(|imm_q[31:11]));
            end
            3'd2: begin
                enc_word[31:25] = imm_q[11:5];
                enc_word[11:7]  = imm_q[4:0];
                enc_err = !((&imm_q[31:11]) || !(|imm_q[31:11]));
            end
            3'd3: begin
                enc_word[31]    = imm_q[12];
                enc_word[30:25] = imm_q[10:5];
                enc_word[11:8]  = imm_q[4:1];
                enc_word[7]     = imm_q[11];
                enc_err = !((&imm_q[31:12]) || !(|imm_q[31:12])) || imm_q[0];
            end
            3'd4: begin
                enc_word[31:12] = imm_q[31:12];
                enc_err = |imm_q[11:0];
            end
            3'd5: begin
                enc_word[31]    = imm_q[20];
                enc_word[30:21] = imm_q[10:1];
                enc_word[20]    = imm_q[11];
                enc_word[19:12] = imm_q[19:12];
                enc_err = !((&imm_q[31:20]) || !(|imm_q[31:20])) || imm_q[0];
            end
            default: enc_err = 1'b1;
        endcase
        if (enc_err) begin
            enc_word = NOP;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            fmt_q   <= 3'd0;
            imm_q   <= 32'd0;
            base_q  <= 32'd0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            instr_q <= 32'd0;
            addr_q  <= START_ADDR;
            cnt_q   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clear_i) begin
                        addr_q <= START_ADDR;
                        cnt_q  <= 8'd0;
                    end
                    if (bus.valid_i) begin
                        fmt_q   <= bus.format_i;
                        imm_q   <= bus.immediate_i;
                        base_q  <= bus.base_i;
                        ready_q <= 1'b0;
                        state   <= ENCODE;
                    end
                end
                ENCODE: begin
                    instr_q <= enc_word;
                    err_q   <= enc_err;
                    valid_q <= 1'b1;
                    state   <= OUTPUT;
                end
                OUTPUT: begin
                    // Rejected words do not consume an address slot.
                    if (bus.ready_i) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                        if (err_q) begin
                            if (cnt_q != 8'd255) begin
                                cnt_q <= cnt_q + 8'd1;
                            end
                        end else begin
                            addr_q <= addr_q + 32'd4;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_immediate_encoder.sv
// tb/tb_immediate_encoder.sv - scoreboard bench for immediate_encoder
module tb_immediate_encoder;
    localparam logic [31:0] START = 32'h0040_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total = 0;
    exp_t exp_q[$];

    immediate_encoder_if bus ();

    immediate_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, want);
    endtask

    task automatic expect_word(input logic [31:0] instr, input logic [31:0] addr, input logic err);
        exp_t e;
        e.instr = instr;
        e.addr  = addr;
        e.err   = err;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [2:0] f, input logic [31:0] imm, input logic [31:0] base);
        int n = 0;
        @(negedge clk);
        bus.format_i    = f;
        bus.immediate_i = imm;
        bus.base_i      = base;
        bus.valid_i     = 1'b1;
        while (!bus.ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            $display("FAIL accept_timeout: ready_o stuck at %b expected 1", bus.ready_o);
        end
        @(posedge clk);
        #1 bus.valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || !bus.ready_o || bus.valid_o) && n < 500);
        if (n >= 500) begin
            total++;
            $display("FAIL drain_timeout: %0d words outstanding expected 0", exp_q.size());
        end
    endtask

    // Monitor: every output handshake is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (reset && bus.valid_o && bus.ready_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_output: got %h expected no word", bus.instruction_o);
                end else begin
                    e = exp_q.pop_front();
                    check("instruction", bus.instruction_o, e.instr);
                    check("address", bus.address_o, e.addr);
                    check("error", {31'd0, bus.error_o}, {31'd0, e.err});
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        bus.format_i = 3'd0;
        bus.immediate_i = 32'd0;
        bus.base_i = 32'd0;
        bus.valid_i = 1'b0;
        bus.clear_i = 1'b0;
        bus.ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, bus.ready_o}, 32'd1);
        check("rst_valid", {31'd0, bus.valid_o}, 32'd0);
        check("rst_error", {31'd0, bus.error_o}, 32'd0);
        check("rst_instr", bus.instruction_o, 32'd0);
        check("rst_addr", bus.address_o, START);
        check("rst_errcnt", {24'd0, bus.err_count_o}, 32'd0);
        reset = 1'b1;

        // Good words of every format.
        expect_word(32'hFFF0_0093, 32'h0040_0000, 1'b0); send(3'd1, 32'hFFFF_FFFF, 32'h0000_0093);
        expect_word(32'h7E00_2E23, 32'h0040_0004, 1'b0); send(3'd2, 32'h0000_07FC, 32'h0000_2023);
        expect_word(32'hFE00_0EE3, 32'h0040_0008, 1'b0); send(3'd3, 32'hFFFF_FFFC, 32'h0000_0063);
        expect_word(32'h1234_5037, 32'h0040_000C, 1'b0); send(3'd4, 32'h1234_5000, 32'h0000_0037);
        expect_word(32'h0080_006F, 32'h0040_0010, 1'b0); send(3'd5, 32'h0000_0008, 32'h0000_006F);

        // Unencodable immediates: NOP, address held.
        expect_word(NOP, 32'h0040_0014, 1'b1); send(3'd1, 32'h0000_0800, 32'h0000_0093);
        expect_word(NOP, 32'h0040_0014, 1'b1); send(3'd3, 32'h0000_0005, 32'h0000_0063);
        expect_word(NOP, 32'h0040_0014, 1'b1); send(3'd4, 32'h0000_0001, 32'h0000_0037);
        expect_word(NOP, 32'h0040_0014, 1'b1); send(3'd7, 32'h0000_0000, 32'h0000_0013);
        drain();
        check("errcnt_4", {24'd0, bus.err_count_o}, 32'd4);
        check("addr_after_err", bus.address_o, 32'h0040_0014);

        // Backpressure: held output, second request waits for the handshake.
        bus.ready_i = 1'b0;
        expect_word(32'h0050_0013, 32'h0040_0014, 1'b0);
        send(3'd1, 32'h0000_0005, 32'h0000_0013);
        @(negedge clk);
        check("encode_valid", {31'd0, bus.valid_o}, 32'd0);
        check("encode_ready", {31'd0, bus.ready_o}, 32'd0);
        @(negedge clk);
        bus.format_i = 3'd4;
        bus.immediate_i = 32'hABCD_E000;
        bus.base_i = 32'h0000_0037;
        bus.valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", {31'd0, bus.valid_o}, 32'd1);
            check("stall_instr", bus.instruction_o, 32'h0050_0013);
            check("stall_addr", bus.address_o, 32'h0040_0014);
            check("stall_ready", {31'd0, bus.ready_o}, 32'd0);
            @(negedge clk);
        end
        bus.ready_i = 1'b1;
        expect_word(32'hABCD_E037, 32'h0040_0018, 1'b0);
        send(3'd4, 32'hABCD_E000, 32'h0000_0037);
        drain();

        // clear_i while in OUTPUT must be ignored.
        bus.ready_i = 1'b0;
        expect_word(32'h0010_0093, 32'h0040_001C, 1'b0);
        send(3'd1, 32'h0000_0001, 32'h0000_0093);
        repeat (2) @(negedge clk);
        bus.clear_i = 1'b1;
        repeat (2) @(negedge clk);
        bus.clear_i = 1'b0;
        bus.ready_i = 1'b1;
        drain();
        check("clr_output_addr", bus.address_o, 32'h0040_0020);
        check("clr_output_errcnt", {24'd0, bus.err_count_o}, 32'd4);

        // clear_i in IDLE.
        bus.clear_i = 1'b1;
        @(negedge clk);
        bus.clear_i = 1'b0;
        check("clr_idle_addr", bus.address_o, START);
        check("clr_idle_errcnt", {24'd0, bus.err_count_o}, 32'd0);

        // Error counter saturation.
        for (int i = 0; i < 260; i++) begin
            expect_word(NOP, START, 1'b1);
            send(3'd6, 32'h0000_0000, 32'h0000_0000);
        end
        drain();
        check("errcnt_sat", {24'd0, bus.err_count_o}, 32'd255);
        expect_word(32'hFFDF_F06F, START, 1'b0); send(3'd5, 32'hFFFF_FFFC, 32'h0000_006F);
        drain();
        check("addr_after_sat", bus.address_o, START + 32'd4);

        // Reset while in ENCODE discards the word.
        @(negedge clk);
        bus.format_i = 3'd1;
        bus.immediate_i = 32'h0000_0010;
        bus.base_i = 32'h0000_0093;
        bus.valid_i = 1'b1;
        @(posedge clk);
        #1 bus.valid_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("rst_enc_valid", {31'd0, bus.valid_o}, 32'd0);
        check("rst_enc_addr", bus.address_o, START);
        check("rst_enc_ready", {31'd0, bus.ready_o}, 32'd1);
        check("rst_enc_errcnt", {24'd0, bus.err_count_o}, 32'd0);
        repeat (3) @(negedge clk);
        check("rst_enc_no_out", {31'd0, bus.valid_o}, 32'd0);

        expect_word(32'h0080_006F, START, 1'b0); send(3'd5, 32'h0000_0008, 32'h0000_006F);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
